// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA key-generation datapath blocks.
package rsa_pkg;

    localparam int W  = 64;      // operand width
    localparam int TW = W + 2;   // signed Bezout-coefficient width

    localparam logic ON  = 1'b1;
    localparam logic OFF = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        TEST,
        ALIGN,
        DIV,
        UPDATE,
        FIX,
        DONE
    } state_e;

endpackage

// File: rtl/create_d_shift_sub_step.sv
// One cycle of the bit-serial divider: either an ALIGN (left-shift) step or a
// DIV (conditional subtract, then right-shift) step on the quotient datapath.
// The coefficient track (tsh/tacc) follows the remainder track so that
// tacc accumulates t0 - q*t1 without a multiplier.
module shift_sub_step
    import rsa_pkg::*;
#(
    parameter int W  = rsa_pkg::W,
    parameter int TW = W + 2
) (
    input  logic          div_i,    // 0: ALIGN step, 1: DIV step
    input  logic [W-1:0]  rem_i,
    input  logic [W-1:0]  dsh_i,
    input  logic [TW-1:0] tsh_i,
    input  logic [TW-1:0] tacc_i,
    output logic [W-1:0]  rem_o,
    output logic [W-1:0]  dsh_o,
    output logic [TW-1:0] tsh_o,
    output logic [TW-1:0] tacc_o,
    output logic          grow_o    // divisor can still be doubled without passing rem
);

    logic [W-1:0] dsh_x2;
    logic         rem_ge;

    assign dsh_x2 = {dsh_i[W-2:0], 1'b0};
    // The MSB test keeps the doubled divisor inside W bits.
    assign grow_o = ~dsh_i[W-1] && (dsh_x2 <= rem_i);
    assign rem_ge = (rem_i >= dsh_i);

    // Combinational step: align doubles divisor/coefficient, div emits one quotient bit.
    always_comb begin
        rem_o  = rem_i;
        dsh_o  = dsh_i;
        tsh_o  = tsh_i;
        tacc_o = tacc_i;
        if (!div_i) begin
            if (grow_o) begin
                dsh_o = dsh_x2;
                tsh_o = {tsh_i[TW-2:0], 1'b0};
            end
        end else begin
            if (rem_ge) begin
                rem_o  = rem_i - dsh_i;
                tacc_o = tacc_i - tsh_i;
            end
            dsh_o = {1'b0, dsh_i[W-1:1]};
            // tsh was only shifted left by k, so the arithmetic shift undoes it exactly.
            tsh_o = $signed(tsh_i) >>> 1;
        end
    end

endmodule

// File: rtl/create_d.sv
// RSA private exponent D = E^-1 mod L via iterative extended Euclid.
// Quotients come from the shift_sub_step bit-serial divider; coefficients are
// tracked in TW-bit two's complement and folded into [0, L-1] at the end.
module create_d
    import rsa_pkg::*;
#(
    parameter int W  = rsa_pkg::W,
    parameter int TW = W + 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_n,
    input  logic [W-1:0] E,
    input  logic [W-1:0] L,
    output logic [W-1:0] D,
    output logic         ready_n,
    output logic         fail
);

    localparam int KW = $clog2(W);
    localparam logic [TW-1:0] T_ONE = {{(TW-1){1'b0}}, 1'b1};

    state_e state_q, state_d;

    logic [W-1:0]  l_q, l_d;
    logic [W-1:0]  r0_q, r0_d, r1_q, r1_d;
    logic [TW-1:0] t0_q, t0_d, t1_q, t1_d;
    logic [W-1:0]  rem_q, rem_d, dsh_q, dsh_d;
    logic [TW-1:0] tsh_q, tsh_d, tacc_q, tacc_d;
    logic [KW-1:0] k_q, k_d;
    logic [W-1:0]  d_q, d_d;
    logic          fail_q, fail_d;
    logic          ready_n_q, ready_n_d;

    logic [W-1:0]  st_rem, st_dsh;
    logic [TW-1:0] st_tsh, st_tacc;
    logic          grow;
    logic          reject;

    shift_sub_step #(.W(W), .TW(TW)) u_step (
        .div_i  (state_q == DIV),
        .rem_i  (rem_q),
        .dsh_i  (dsh_q),
        .tsh_i  (tsh_q),
        .tacc_i (tacc_q),
        .rem_o  (st_rem),
        .dsh_o  (st_dsh),
        .tsh_o  (st_tsh),
        .tacc_o (st_tacc),
        .grow_o (grow)
    );

    // No inverse when L<2, E=0, or E>=L (r1 holds E during CHECK).
    assign reject = (l_q[W-1:1] == '0) || (r1_q == '0) || (r1_q >= l_q);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; start_n overrides any run in progress.
    always_comb begin
        state_d = state_q;
        if (!start_n) begin
            state_d = CHECK;
        end else begin
            case (state_q)
                CHECK:   state_d = reject ? DONE : TEST;
                TEST:    state_d = (r1_q == '0) ? FIX : ALIGN;
                ALIGN:   if (!grow) state_d = DIV;
                DIV:     if (k_q == '0) state_d = UPDATE;
                UPDATE:  state_d = TEST;
                FIX:     state_d = DONE;
                default: state_d = state_q;   // IDLE and DONE hold
            endcase
        end
    end

    // Output next-state: result/fail written in CHECK or FIX, ready_n low only in DONE.
    always_comb begin
        d_d       = d_q;
        fail_d    = fail_q;
        ready_n_d = ON;
        if (!start_n) begin
            fail_d = OFF;
        end else begin
            case (state_q)
                CHECK: if (reject) begin
                    fail_d = ON;
                    d_d    = '0;
                end
                FIX: if (r0_q != {{(W-1){1'b0}}, 1'b1}) begin
                    fail_d = ON;
                    d_d    = '0;
                end else begin
                    d_d = t0_q[TW-1] ? (t0_q[W-1:0] + l_q) : t0_q[W-1:0];
                end
                DONE:    ready_n_d = OFF;
                default: ;
            endcase
        end
    end

    // Euclid and divider datapath next-state.
    always_comb begin
        l_d    = l_q;
        r0_d   = r0_q;
        r1_d   = r1_q;
        t0_d   = t0_q;
        t1_d   = t1_q;
        rem_d  = rem_q;
        dsh_d  = dsh_q;
        tsh_d  = tsh_q;
        tacc_d = tacc_q;
        k_d    = k_q;
        if (!start_n) begin
            l_d  = L;
            r0_d = L;
            r1_d = E;
            t0_d = '0;
            t1_d = T_ONE;
        end else begin
            case (state_q)
                TEST: begin
                    rem_d  = r0_q;
                    dsh_d  = r1_q;
                    tsh_d  = t1_q;
                    tacc_d = t0_q;
                    k_d    = '0;
                end
                ALIGN: if (grow) begin
                    dsh_d = st_dsh;
                    tsh_d = st_tsh;
                    k_d   = k_q + 1'b1;
                end
                DIV: begin
                    rem_d  = st_rem;
                    dsh_d  = st_dsh;
                    tsh_d  = st_tsh;
                    tacc_d = st_tacc;
                    if (k_q != '0) k_d = k_q - 1'b1;
                end
                UPDATE: begin
                    r0_d = r1_q;
                    r1_d = rem_q;
                    t0_d = t1_q;
                    t1_d = tacc_q;
                end
                default: ;
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            l_q       <= '0;
            r0_q      <= '0;
            r1_q      <= '0;
            t0_q      <= '0;
            t1_q      <= '0;
            rem_q     <= '0;
            dsh_q     <= '0;
            tsh_q     <= '0;
            tacc_q    <= '0;
            k_q       <= '0;
            d_q       <= '0;
            fail_q    <= OFF;
            ready_n_q <= ON;
        end else begin
            l_q       <= l_d;
            r0_q      <= r0_d;
            r1_q      <= r1_d;
            t0_q      <= t0_d;
            t1_q      <= t1_d;
            rem_q     <= rem_d;
            dsh_q     <= dsh_d;
            tsh_q     <= tsh_d;
            tacc_q    <= tacc_d;
            k_q       <= k_d;
            d_q       <= d_d;
            fail_q    <= fail_d;
            ready_n_q <= ready_n_d;
        end
    end

    assign D       = d_q;
    assign fail    = fail_q;
    assign ready_n = ready_n_q;

endmodule

// File: tb/tb_create_d.sv
// Scoreboard bench for create_d: expected (D, fail) pushed at start, popped on ready_n.
module tb_create_d;

    typedef struct packed {
        logic        fail;
        logic [63:0] d;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start_n;
    logic [63:0] E;
    logic [63:0] L;
    logic [63:0] D;
    logic        ready_n;
    logic        fail;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    create_d #(.W(64), .TW(66)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_n (start_n),
        .E       (E),
        .L       (L),
        .D       (D),
        .ready_n (ready_n),
        .fail    (fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Independent reference: extended Euclid with native division and wide signed coefficients.
    task automatic ref_inv(input logic [63:0] e, input logic [63:0] l,
                           output logic [63:0] g, output logic [63:0] d);
        logic [63:0] a, b, q, r;
        logic signed [129:0] t0, t1, tn, qs, ls;
        a = l; b = e; t0 = 0; t1 = 1;
        while (b != 0) begin
            q  = a / b;
            r  = a % b;
            qs = $signed({66'd0, q});
            tn = t0 - qs * t1;
            t0 = t1; t1 = tn;
            a  = b;  b  = r;
        end
        ls = $signed({66'd0, l});
        if (t0 < 0) t0 = t0 + ls;
        g = a;
        d = t0[63:0];
    endtask

    // Latch (l, e), then scramble the inputs to show they are no longer observed.
    task automatic kick(input logic [63:0] l, input logic [63:0] e);
        logic [63:0] prev_d;
        @(negedge clk);
        prev_d  = D;
        L       = l;
        E       = e;
        start_n = 1'b0;
        @(negedge clk);
        chk("latch_rdy", ready_n, 1'b1);
        chk("latch_fail", fail, 1'b0);
        chk("latch_hold_d", D, prev_d);
        start_n = 1'b1;
        L = {$urandom(), $urandom()};
        E = {$urandom(), $urandom()};
    endtask

    // Full run: push expectation, start, wait (bounded) for ready_n, compare.
    task automatic run(input logic [63:0] l, input logic [63:0] e,
                       input logic exp_fail, input logic [63:0] exp_d, output int cyc);
        exp_t x;
        sb.push_back({exp_fail, exp_d});
        kick(l, e);
        cyc = 0;
        while (ready_n && cyc < 13000) begin
            @(negedge clk);
            cyc++;
        end
        x = sb.pop_front();
        if (ready_n) begin
            chk("timeout", 1'b1, 1'b0);
        end else begin
            chk("fail", fail, x.fail);
            chk("D", D, x.d);
        end
    endtask

    initial begin
        int cyc;
        logic [63:0] rl, re, g, dref;
        logic [127:0] prod;

        rst_n = 1'b0; start_n = 1'b1; E = '0; L = '0;
        repeat (3) @(negedge clk);
        chk("rst_rdy", ready_n, 1'b1);
        chk("rst_fail", fail, 1'b0);
        chk("rst_D", D, 64'd0);
        rst_n = 1'b1;

        run(64'd20, 64'd3, 1'b0, 64'd7, cyc);
        chk("lat_20_3", cyc < 200, 1'b1);
        run(64'd30, 64'd7, 1'b0, 64'd13, cyc);
        run(64'd30, 64'd1, 1'b0, 64'd1, cyc);
        run(64'd30, 64'd29, 1'b0, 64'd29, cyc);
        run(64'd20, 64'd6, 1'b1, 64'd0, cyc);

        run(64'd30, 64'd0, 1'b1, 64'd0, cyc);
        chk("early_e0", cyc, 2);
        run(64'd1, 64'd0, 1'b1, 64'd0, cyc);
        chk("early_l1", cyc, 2);
        run(64'd7, 64'd9, 1'b1, 64'd0, cyc);
        chk("early_ege", cyc, 2);

        run(64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 1'b0, 64'h5555_5555_5555_5555, cyc);
        chk("lat_big", cyc < 12300, 1'b1);

        // Abort a long run with a fresh start; only the new result may appear.
        kick(64'hFFFF_FFFF_FFFF_FFFE, 64'd3);
        repeat (20) @(negedge clk);
        chk("mid_rdy", ready_n, 1'b1);
        run(64'd20, 64'd3, 1'b0, 64'd7, cyc);

        // Reset mid-run clears everything on the next edge.
        kick(64'hFFFF_FFFF_FFFF_FFFE, 64'd3);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_rdy", ready_n, 1'b1);
        chk("mrst_fail", fail, 1'b0);
        chk("mrst_D", D, 64'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("mrst_idle", ready_n, 1'b1);

        for (int i = 0; i < 10; i++) begin
            g = 0;
            while (g != 1) begin
                rl = {$urandom(), $urandom()};
                if (rl < 64'd3) rl = 64'd3;
                re = {$urandom(), $urandom()} % rl;
                if (re == 0) re = 1;
                ref_inv(re, rl, g, dref);
            end
            run(rl, re, 1'b0, dref, cyc);
            prod = {64'd0, re} * {64'd0, D};
            chk("rnd_mod", prod % {64'd0, rl}, 128'd1);
            chk("rnd_lt", D < rl, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
